// File: rtl/code_serializer_pkg.sv
// rtl/code_serializer_pkg.sv - shared state encoding and default frame constants
package code_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int CODE_WIDTH = 8;
   localparam int CODE_GAP   = 2;

endpackage

// File: rtl/code_serializer_if.sv
// rtl/code_serializer_if.sv - word handshake and serial line bundle
interface code_serializer_if #(
   parameter int WIDTH = code_pkg::CODE_WIDTH
);

   logic [WIDTH-1:0] data_in;
   logic             data_valid;
   logic             data_ready;
   logic             code;
   logic             code_valid;
   logic             busy;
   logic             frame_done;

   modport master (
      output data_in, data_valid,
      input  data_ready, code, code_valid, busy, frame_done
   );

   modport slave (
      input  data_in, data_valid,
      output data_ready, code, code_valid, busy, frame_done
   );

endinterface

// File: rtl/code_serializer.sv
// rtl/code_serializer.sv - parallel word to serial code stream with idle gap
module code_serializer
   import code_pkg::*;
#(
   parameter int   WIDTH      = CODE_WIDTH,
   parameter int   GAP_CYCLES = CODE_GAP,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic                clock,
   input  logic                reset,
   code_serializer_if.slave    bus
);

   localparam int CW = $clog2(WIDTH);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   state_t           state_q,      state_d;
   logic [WIDTH-1:0] shift_q,      shift_d;
   logic [CW-1:0]    bit_cnt_q,    bit_cnt_d;
   logic [GW-1:0]    gap_cnt_q,    gap_cnt_d;
   logic             code_q,       code_d;
   logic             code_valid_q, code_valid_d;
   logic             busy_q,       busy_d;
   logic             frame_done_q, frame_done_d;
   logic             data_ready_q, data_ready_d;

   // The shift register always holds the bits still to be sent, aligned so
   // the next one sits at the outgoing end.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   function automatic logic out_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      code_d       = IDLE_LEVEL;
      code_valid_d = 1'b0;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      data_ready_d = data_ready_q;

      case (state_q)
         SHIFT: begin
            if (bit_cnt_q == '0) begin
               frame_done_d = 1'b1;
               if (GAP_CYCLES > 0) begin
                  state_d      = GAP;
                  gap_cnt_d    = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
                  busy_d       = 1'b1;
                  data_ready_d = 1'b0;
               end else begin
                  state_d      = IDLE;
                  busy_d       = 1'b0;
                  data_ready_d = 1'b1;
               end
            end else begin
               bit_cnt_d    = bit_cnt_q - 1'b1;
               code_d       = out_bit(shift_q);
               code_valid_d = 1'b1;
               shift_d      = advance(shift_q);
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) begin
               state_d      = IDLE;
               busy_d       = 1'b0;
               data_ready_d = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: begin
            // The unused encoding lands here too and recovers as IDLE.
            state_d      = IDLE;
            busy_d       = 1'b0;
            data_ready_d = 1'b1;
            if (bus.data_valid && data_ready_q) begin
               state_d      = SHIFT;
               shift_d      = advance(bus.data_in);
               bit_cnt_d    = CW'(WIDTH - 1);
               code_d       = out_bit(bus.data_in);
               code_valid_d = 1'b1;
               busy_d       = 1'b1;
               data_ready_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         code_q       <= IDLE_LEVEL;
         code_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         data_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         data_ready_q <= data_ready_d;
      end
   end

   assign bus.code       = code_q;
   assign bus.code_valid = code_valid_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;
   assign bus.data_ready = data_ready_q;

endmodule

// File: tb/tb_code_serializer.sv
// tb/tb_code_serializer.sv - scoreboard bench for code_serializer in two configurations
module tb_code_serializer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   code_serializer_if #(.WIDTH(8)) bus_a ();
   code_serializer_if #(.WIDTH(8)) bus_b ();

   code_serializer #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus_a)
   );

   code_serializer #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus_b)
   );

   int   tests = 0;
   int   fails = 0;
   logic exp_a[$];
   logic exp_b[$];
   int   fd_exp_a = 0, fd_exp_b = 0;
   int   fd_seen_a = 0, fd_seen_b = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: pop one expected bit per code_valid cycle, count frame_done pulses.
   always @(negedge clk) begin
      if (bus_a.code_valid === 1'b1) begin
         if (exp_a.size() == 0) chk("a_unexpected_bit", 32'd1, 32'd0);
         else chk("a_bit", {31'd0, bus_a.code}, {31'd0, exp_a.pop_front()});
      end
      if (bus_a.frame_done === 1'b1) fd_seen_a++;
   end

   always @(negedge clk) begin
      if (bus_b.code_valid === 1'b1) begin
         if (exp_b.size() == 0) chk("b_unexpected_bit", 32'd1, 32'd0);
         else chk("b_bit", {31'd0, bus_b.code}, {31'd0, exp_b.pop_front()});
      end
      if (bus_b.frame_done === 1'b1) fd_seen_b++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers w to DUT sel (0 = MSB-first gap 2, 1 = LSB-first gap 0); returns on the cycle after accept.
   task automatic send(input int sel, input logic [7:0] w, input bit hold, output int acc);
      bit ok = 1'b0;
      logic rdy;
      acc = -1;
      if (sel == 0) begin bus_a.data_in = w; bus_a.data_valid = 1'b1; end
      else          begin bus_b.data_in = w; bus_b.data_valid = 1'b1; end
      for (int n = 0; n < 40; n++) begin
         rdy = (sel == 0) ? bus_a.data_ready : bus_b.data_ready;
         if (rdy === 1'b1) begin
            for (int i = 0; i < 8; i++) begin
               if (sel == 0) begin exp_a.push_back(w[7-i]); end
               else          begin exp_b.push_back(w[i]); end
            end
            if (sel == 0) fd_exp_a++; else fd_exp_b++;
            step();
            acc = cyc;
            ok  = 1'b1;
            break;
         end
         step();
      end
      if (!hold) begin
         if (sel == 0) bus_a.data_valid = 1'b0; else bus_b.data_valid = 1'b0;
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   int c1, c2;
   logic [3:0] got, want;

   initial begin
      bus_a.data_in = '0; bus_a.data_valid = 1'b0;
      bus_b.data_in = '0; bus_b.data_valid = 1'b0;

      rst_n = 1'b0;
      step(); step();
      chk("rst_a_code",       {31'd0, bus_a.code},       32'd0);
      chk("rst_a_code_valid", {31'd0, bus_a.code_valid}, 32'd0);
      chk("rst_a_busy",       {31'd0, bus_a.busy},       32'd0);
      chk("rst_a_frame_done", {31'd0, bus_a.frame_done}, 32'd0);
      chk("rst_a_data_ready", {31'd0, bus_a.data_ready}, 32'd1);
      chk("rst_b_data_ready", {31'd0, bus_b.data_ready}, 32'd1);
      rst_n = 1'b1;
      step();

      // Single frame 1011_0010: bits k=1..8, frame_done k=9, gap k=9..10, ready at k=11.
      send(0, 8'b1011_0010, 1'b0, c1);
      for (int k = 1; k <= 11; k++) begin
         got  = {bus_a.code_valid, bus_a.frame_done, bus_a.data_ready, bus_a.busy};
         want = {k <= 8, k == 9, k == 11, k <= 10};
         chk($sformatf("a_timing_k%0d", k), {28'd0, got}, {28'd0, want});
         if (k < 11) step();
      end

      // Back-to-back with valid held; second word must wait one full period.
      send(0, 8'hA5, 1'b1, c1);
      send(0, 8'h3C, 1'b0, c2);
      chk("a_b2b_spacing", c2 - c1, 32'd11);
      repeat (12) step();

      // Reset during the 4th bit of 8'hFF discards the frame.
      send(0, 8'hFF, 1'b0, c1);
      step(); step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      exp_a.delete();
      fd_exp_a--;
      chk("a_midrst_code",       {31'd0, bus_a.code},       32'd0);
      chk("a_midrst_code_valid", {31'd0, bus_a.code_valid}, 32'd0);
      chk("a_midrst_frame_done", {31'd0, bus_a.frame_done}, 32'd0);
      repeat (4) step();
      send(0, 8'h81, 1'b0, c1);
      repeat (12) step();

      // LSB first, no gap: frame_done lands in the ready IDLE cycle, accept on the next edge.
      send(1, 8'b0000_0001, 1'b0, c1);
      for (int k = 1; k <= 9; k++) begin
         got  = {bus_b.code_valid, bus_b.frame_done, bus_b.data_ready, bus_b.busy};
         want = {k <= 8, k == 9, k == 9, k <= 8};
         chk($sformatf("b_timing_k%0d", k), {28'd0, got}, {28'd0, want});
         if (k < 9) step();
      end
      send(1, 8'hC6, 1'b0, c2);
      chk("b_b2b_spacing", c2 - c1, 32'd9);
      repeat (12) step();

      chk("a_frame_done_count", fd_seen_a, fd_exp_a);
      chk("b_frame_done_count", fd_seen_b, fd_exp_b);
      chk("a_bits_left", exp_a.size(), 32'd0);
      chk("b_bits_left", exp_b.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
